// File: rtl/i2s_core.sv
// I2S master core: derives BCLK/WCLK from adc_clk, serializes a stereo TX pair
// and deserializes the stereo RX stream in standard (one-bit-delayed) I2S format.
module i2s_core #(
  parameter int BCLK_DIV    = 8,
  parameter int BITS_PER_CH = 32,
  parameter int DATA_WIDTH  = 24
) (
  input  logic                  adc_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_left,
  input  logic [DATA_WIDTH-1:0] tx_right,
  output logic                  tx_ack,
  input  logic                  i2s_sdin,
  output logic [DATA_WIDTH-1:0] rx_left,
  output logic [DATA_WIDTH-1:0] rx_right,
  output logic                  rx_valid,
  output logic                  i2s_bclk,
  output logic                  i2s_wclk,
  output logic                  i2s_sdout
);

  localparam int CNT_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(BITS_PER_CH);
  localparam int IDX_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_RISE = CNT_W'(BCLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_CH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_DMAX = BIT_W'(DATA_WIDTH);

  logic [CNT_W-1:0]      r_cnt;
  logic [BIT_W-1:0]      r_bitcnt;
  logic                  r_bclk;
  logic                  r_wclk;
  logic                  r_sdout;
  logic                  r_tx_ack;
  logic                  r_rx_valid;
  logic [DATA_WIDTH-1:0] r_hold_l;
  logic [DATA_WIDTH-1:0] r_hold_r;
  logic [DATA_WIDTH-1:0] r_rx_sr;
  logic [DATA_WIDTH-1:0] r_rx_left;
  logic [DATA_WIDTH-1:0] r_rx_right;

  logic                  w_rise;
  logic                  w_fall;
  logic                  w_slot_end;
  logic                  w_wrap;
  logic                  w_frame_start;
  logic                  w_rx_take;
  logic                  w_wclk_nx;
  logic                  w_sdout_nx;
  logic [BIT_W-1:0]      w_bitcnt_nx;
  logic [DATA_WIDTH-1:0] w_word;
  logic [IDX_W-1:0]      w_idx;

  // Tick decode and next transmit bit; bit k of a slot carries W[DATA_WIDTH-k], k=0 is the I2S delay bit.
  always_comb begin
    w_rise        = (r_cnt == CNT_RISE);
    w_fall        = (r_cnt == CNT_LAST);
    w_slot_end    = (r_bitcnt == BIT_LAST);
    w_wrap        = w_fall && w_slot_end;
    w_frame_start = w_wrap && r_wclk;
    w_bitcnt_nx   = w_slot_end ? {BIT_W{1'b0}} : (r_bitcnt + BIT_ONE);
    w_wclk_nx     = w_slot_end ? ~r_wclk : r_wclk;
    w_rx_take     = w_rise && (r_bitcnt >= BIT_ONE) && (r_bitcnt <= BIT_DMAX);
    w_word        = w_wclk_nx ? r_hold_r : r_hold_l;
    w_idx         = IDX_W'(DATA_WIDTH - int'(w_bitcnt_nx));
    w_sdout_nx    = 1'b0;
    if ((w_bitcnt_nx >= BIT_ONE) && (w_bitcnt_nx <= BIT_DMAX)) begin
      w_sdout_nx = w_word[w_idx];
    end else begin
      w_sdout_nx = 1'b0;
    end
  end

  // Clock divider, bit counter and the bclk/wclk/sdout pins.
  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= {CNT_W{1'b0}};
      r_bitcnt <= {BIT_W{1'b0}};
      r_bclk   <= 1'b0;
      r_wclk   <= 1'b0;
      r_sdout  <= 1'b0;
    end else begin
      r_cnt <= w_fall ? {CNT_W{1'b0}} : (r_cnt + CNT_ONE);
      if (w_rise) begin
        r_bclk <= 1'b1;
      end else if (w_fall) begin
        r_bclk <= 1'b0;
      end
      if (w_fall) begin
        r_bitcnt <= w_bitcnt_nx;
        r_wclk   <= w_wclk_nx;
        r_sdout  <= w_sdout_nx;
      end
    end
  end

  // Frame-start latch of the TX pair and the handshake pulses.
  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      r_hold_l   <= {DATA_WIDTH{1'b0}};
      r_hold_r   <= {DATA_WIDTH{1'b0}};
      r_tx_ack   <= 1'b0;
      r_rx_valid <= 1'b0;
    end else begin
      r_tx_ack   <= w_frame_start;
      r_rx_valid <= w_frame_start;
      if (w_frame_start) begin
        r_hold_l <= tx_left;
        r_hold_r <= tx_right;
      end
    end
  end

  // Receive: sdin is already in the adc_clk domain because bclk is generated here.
  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      r_rx_sr    <= {DATA_WIDTH{1'b0}};
      r_rx_left  <= {DATA_WIDTH{1'b0}};
      r_rx_right <= {DATA_WIDTH{1'b0}};
    end else begin
      if (w_rx_take) begin
        r_rx_sr <= {r_rx_sr[DATA_WIDTH-2:0], i2s_sdin};
      end
      if (w_wrap) begin
        if (r_wclk) begin
          r_rx_right <= r_rx_sr;
        end else begin
          r_rx_left <= r_rx_sr;
        end
      end
    end
  end

  assign tx_ack    = r_tx_ack;
  assign rx_valid  = r_rx_valid;
  assign rx_left   = r_rx_left;
  assign rx_right  = r_rx_right;
  assign i2s_bclk  = r_bclk;
  assign i2s_wclk  = r_wclk;
  assign i2s_sdout = r_sdout;

endmodule

// File: tb/tb_i2s_core.sv
// Bench for i2s_core: two instances (default timing and BCLK_DIV=4/BITS_PER_CH=25) checked
// every adc_clk against a model that derives the expected pins from the edge count since reset.
module tb_i2s_core;

  localparam int DW    = 24;
  localparam int DIV0  = 8;
  localparam int BITS0 = 32;
  localparam int DIV1  = 4;
  localparam int BITS1 = 25;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          loop_en;
  logic          rnd0, rnd1;
  logic [DW-1:0] txl0, txr0, txl1, txr1;
  logic          sdin0, sdin1;
  logic          ack0, val0, bclk0, wclk0, sdo0;
  logic          ack1, val1, bclk1, wclk1, sdo1;
  logic [DW-1:0] rxl0, rxr0, rxl1, rxr1;

  assign sdin0 = loop_en ? sdo0 : rnd0;
  assign sdin1 = loop_en ? sdo1 : rnd1;

  i2s_core dut0 (
    .adc_clk(clk), .rst(rst), .tx_left(txl0), .tx_right(txr0), .tx_ack(ack0),
    .i2s_sdin(sdin0), .rx_left(rxl0), .rx_right(rxr0), .rx_valid(val0),
    .i2s_bclk(bclk0), .i2s_wclk(wclk0), .i2s_sdout(sdo0)
  );

  i2s_core #(.BCLK_DIV(DIV1), .BITS_PER_CH(BITS1), .DATA_WIDTH(DW)) dut1 (
    .adc_clk(clk), .rst(rst), .tx_left(txl1), .tx_right(txr1), .tx_ack(ack1),
    .i2s_sdin(sdin1), .rx_left(rxl1), .rx_right(rxr1), .rx_valid(val1),
    .i2s_bclk(bclk1), .i2s_wclk(wclk1), .i2s_sdout(sdo1)
  );

  int vectors     = 0;
  int miscompares = 0;
  int e           = 0;

  logic [DW-1:0] m_hold_l [2];
  logic [DW-1:0] m_hold_r [2];
  logic [DW-1:0] m_sr     [2];
  logic [DW-1:0] m_rxl    [2];
  logic [DW-1:0] m_rxr    [2];
  logic          m_sdin   [2];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_hold_l[d] = '0;
      m_hold_r[d] = '0;
      m_sr[d]     = '0;
      m_rxl[d]    = '0;
      m_rxr[d]    = '0;
      m_sdin[d]   = 1'b0;
    end
  endtask

  // Effect of adc_clk edge number e: bclk rises when e%div==div/2, falls when e%div==0.
  task automatic model_edge(input int d, input int div, input int bits,
                            input logic [DW-1:0] txl, input logic [DW-1:0] txr);
    int nf, k;
    if (e % div == div / 2) begin
      k = (e / div) % bits;
      if (k >= 1 && k <= DW) m_sr[d] = {m_sr[d][DW-2:0], m_sdin[d]};
    end
    if (e % div == 0) begin
      nf = e / div;
      if (nf % bits == 0) begin
        if (((nf / bits) - 1) % 2 == 0) m_rxl[d] = m_sr[d];
        else m_rxr[d] = m_sr[d];
        if (nf % (2 * bits) == 0) begin
          m_hold_l[d] = txl;
          m_hold_r[d] = txr;
        end
      end
    end
  endtask

  function automatic logic exp_sdout(input int d, input int div, input int bits);
    int nf, k;
    logic [DW-1:0] w;
    nf = e / div;
    k  = nf % bits;
    w  = ((nf / bits) % 2 == 1) ? m_hold_r[d] : m_hold_l[d];
    if (k >= 1 && k <= DW) begin
      w = w >> (DW - k);
      return w[0];
    end
    return 1'b0;
  endfunction

  task automatic check_dut(input int d, input int div, input int bits,
                           input logic bclk, input logic wclk, input logic sdo,
                           input logic ack, input logic val,
                           input logic [DW-1:0] rxl, input logic [DW-1:0] rxr);
    logic ack_e;
    ack_e = (e > 0) && (e % (2 * bits * div) == 0);
    chk($sformatf("d%0d_bclk", d),  DW'(bclk), DW'((e % div) >= div / 2));
    chk($sformatf("d%0d_wclk", d),  DW'(wclk), DW'(((e / div) / bits) % 2));
    chk($sformatf("d%0d_sdout", d), DW'(sdo),  DW'(exp_sdout(d, div, bits)));
    chk($sformatf("d%0d_tx_ack", d), DW'(ack), DW'(ack_e));
    chk($sformatf("d%0d_rx_valid", d), DW'(val), DW'(ack_e));
    chk($sformatf("d%0d_rx_left", d),  rxl, m_rxl[d]);
    chk($sformatf("d%0d_rx_right", d), rxr, m_rxr[d]);
  endtask

  task automatic step(input bit rand_tx, input bit rand_sdin);
    @(negedge clk);
    if (rst) begin
      e = 0;
      model_reset();
    end else begin
      e++;
      model_edge(0, DIV0, BITS0, txl0, txr0);
      model_edge(1, DIV1, BITS1, txl1, txr1);
    end
    check_dut(0, DIV0, BITS0, bclk0, wclk0, sdo0, ack0, val0, rxl0, rxr0);
    check_dut(1, DIV1, BITS1, bclk1, wclk1, sdo1, ack1, val1, rxl1, rxr1);
    if (rand_tx && ($urandom_range(0, 7) == 0)) begin
      txl0 = DW'($urandom);
      txr0 = DW'($urandom);
      txl1 = DW'($urandom);
      txr1 = DW'($urandom);
    end
    rnd0 = rand_sdin ? 1'($urandom_range(0, 1)) : 1'b0;
    rnd1 = rand_sdin ? 1'($urandom_range(0, 1)) : 1'b0;
    m_sdin[0] = loop_en ? exp_sdout(0, DIV0, BITS0) : rnd0;
    m_sdin[1] = loop_en ? exp_sdout(1, DIV1, BITS1) : rnd1;
  endtask

  task automatic run_to(input int target, input bit rand_tx, input bit rand_sdin);
    while (e < target) step(rand_tx, rand_sdin);
  endtask

  initial begin
    rst     = 1'b0;
    loop_en = 1'b1;
    rnd0    = 1'b0;
    rnd1    = 1'b0;
    txl0    = 24'hA5F00F;
    txr0    = 24'h123456;
    txl1    = 24'h800001;
    txr1    = 24'h7FFFFE;
    model_reset();

    // Reset state, asynchronous (before any clock edge) and across held-reset edges.
    #1 rst = 1'b1;
    #1 check_dut(0, DIV0, BITS0, bclk0, wclk0, sdo0, ack0, val0, rxl0, rxr0);
    check_dut(1, DIV1, BITS1, bclk1, wclk1, sdo1, ack1, val1, rxl1, rxr1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b0;

    // Constant words with sdout looped back to sdin.
    run_to(3 * 512 + 16, 1'b0, 1'b0);
    chk("loop_rx_left",  rxl0, 24'hA5F00F);
    chk("loop_rx_right", rxr0, 24'h123456);
    chk("loop_rx_left_d1",  rxl1, 24'h800001);
    chk("loop_rx_right_d1", rxr1, 24'h7FFFFE);

    // Random TX words changing at arbitrary times, random serial input.
    loop_en = 1'b0;
    run_to(e + 2048, 1'b1, 1'b1);

    // Reset in the middle of the right slot of the default instance.
    while ((e % 512) != 356) step(1'b1, 1'b1);
    rst = 1'b1;
    #1;
    e = 0;
    model_reset();
    check_dut(0, DIV0, BITS0, bclk0, wclk0, sdo0, ack0, val0, rxl0, rxr0);
    check_dut(1, DIV1, BITS1, bclk1, wclk1, sdo1, ack1, val1, rxl1, rxr1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst     = 1'b0;
    loop_en = 1'b1;

    // Restarted timing with random words in loopback.
    run_to(1100, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2s_core.md
Name: i2s_core

Overview:
- I2S master timing and serial-data core, clocked from the 24.576 MHz ADC/audio master clock (adc_clk).
- Derives the bit clock (i2s_bclk) and word-select clock (i2s_wclk) from adc_clk.
- Serializes a stereo transmit word pair and deserializes a stereo receive stream in standard I2S format.
- Sits between the codec/ADC serial pins and the sample-processing logic. Default timing: BCLK = 3.072 MHz, fs = 48 kHz.

Parameters:
- BCLK_DIV, 8: adc_clk cycles per i2s_bclk period. Must be even and >= 2.
- BITS_PER_CH, 32: i2s_bclk periods per channel slot (per i2s_wclk half-period). Must be >= DATA_WIDTH+1.
- DATA_WIDTH, 24: audio sample width, two's complement.

Ports:
- adc_clk, input, 1: sole clock; all logic on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- tx_left, input, DATA_WIDTH: left sample to transmit; sampled at frame start.
- tx_right, input, DATA_WIDTH: right sample to transmit; sampled at frame start.
- tx_ack, output, 1: one-cycle pulse when tx_left/tx_right have been latched.
- i2s_sdin, input, 1: serial data from the codec.
- rx_left, output, DATA_WIDTH: last received left sample.
- rx_right, output, DATA_WIDTH: last received right sample.
- rx_valid, output, 1: one-cycle pulse when a new rx_left/rx_right pair is complete.
- i2s_bclk, output, 1: bit clock, 50% duty.
- i2s_wclk, output, 1: word select; 0 = left, 1 = right.
- i2s_sdout, output, 1: serial data to the codec.

Behaviour:
- All outputs are registers, asynchronously cleared by rst.
- Reset values: i2s_bclk=0, i2s_wclk=0, i2s_sdout=0, tx_ack=0, rx_valid=0, rx_left=0, rx_right=0.
- Internal state reset values: divider cnt=0, bit counter bitcnt=0, tx holding registers=0, rx shift register=0.
- Divider: cnt counts 0..BCLK_DIV-1 and wraps.
  - Rise tick: the edge where cnt==BCLK_DIV/2-1. i2s_bclk<=1.
  - Fall tick: the edge where cnt==BCLK_DIV-1. i2s_bclk<=0.
  - With the default divider, the first bclk rise is at the 4th adc_clk edge after reset release; the period is exactly 8 adc_clk.
- Bit counter: on each fall tick bitcnt increments 0..BITS_PER_CH-1 and wraps.
  - On wrap, i2s_wclk toggles on the same edge as the bclk fall.
  - i2s_wclk is therefore constant for exactly BITS_PER_CH bclk periods and changes only coincident with bclk falling.
  - Frame = 2*BITS_PER_CH bclk periods = 512 adc_clk by default.
- Frame start is the fall tick where i2s_wclk goes 1->0. At that edge:
  - tx_left and tx_right are latched into the holding registers;
  - tx_ack is asserted for one adc_clk cycle.
  - The first frame after reset transmits zeros. First tx_ack: edge 512 after reset release.
- Transmit, updated only on fall ticks. Let k be the new bitcnt and W the holding word for the new i2s_wclk.
  - i2s_sdout <= W[DATA_WIDTH-k] for 1<=k<=DATA_WIDTH.
  - i2s_sdout <= 0 otherwise (k=0 and k>DATA_WIDTH).
  - MSB appears one bclk after the wclk transition, as I2S requires; unused trailing bits are zero.
- Receive: i2s_sdin is sampled on rise ticks. When the current bitcnt is in 1..DATA_WIDTH, the sample is shifted into the rx shift register MSB-first.
  - At each channel wrap the shift register is copied to rx_left (outgoing wclk=0) or rx_right (outgoing wclk=1).
  - The rx_right copy asserts rx_valid for one cycle, on the same edge as tx_ack.
  - rx_left/rx_right hold their values between updates.
- i2s_sdin is in the adc_clk domain, since bclk is generated locally; no synchronizer.
- rst asserted mid-frame: all state returns to reset values immediately. After release, timing restarts from cnt=0, bitcnt=0, left channel.
- tx_left/tx_right changes at any time other than the frame-start edge have no effect on the frame in progress.

Test Plan:
- Reset released, defaults: every i2s_bclk rising edge is 8 adc_clk after the previous one; duty 4 high / 4 low; first rise at adc edge 4.
- Count bclk rises per wclk level: exactly 32 per level. wclk first rises at adc edge 256 and falls at edge 512, each coincident with a bclk fall.
- tx_left=24'hA5F00F, tx_right=24'h123456 held constant:
  - tx_ack pulses at edges 512, 1024, ...;
  - from the second frame, sdout sampled on bclk rises gives 0, then A5F00F MSB-first, then 7 zeros (left slot), then 123456 the same way (right slot).
- Loop i2s_sdout to i2s_sdin: after the third frame start, rx_left=A5F00F and rx_right=123456 with rx_valid pulsing once per 512 adc_clk.
- Assert rst for 3 cycles mid right-slot:
  - outputs go to 0 immediately, with no wait for a clock edge;
  - after release, the bclk/wclk sequence matches the first scenario exactly.
- BCLK_DIV=4, BITS_PER_CH=25: bclk period 4 adc_clk; 25 bclk per wclk level; all 24 data bits are transmitted with one zero slot bit.
